i2s_adc_rx: RTL and testbench

- Receive side of the codec audio link. Deserialises the codec ADC I2S stream (BCK/LRCK/ADCDAT, codec clock slave to our MCLK) into 16-bit left/right samples in the clk24 domain.
- Derives the tape-in bit from the left channel using a hysteresis slicer and a frame-count glitch filter.
- Feeds the tape loader and any line-in consumers.

---
 rtl/i2s_adc_rx.sv | 186 ++++++++++++++++++
 tb/tb_i2s_adc_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_adc_rx.sv
// rtl/i2s_adc_rx.sv - codec ADC I2S receiver with tape-in hysteresis slicer
module i2s_adc_rx #(
    parameter int DATA_BITS = 16,
    parameter int HYST      = 4,
    parameter int GLITCH    = 3
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic        i_bck,
    input  logic        i_lrck,
    input  logic        i_adcdat,
    output logic [15:0] o_left,
    output logic [15:0] o_right,
    output logic        o_valid,
    output logic        o_sync_err,
    output logic        o_tapein
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BITS - 1);
    localparam logic [8:0] HI_TH = 9'(128 + HYST);
    localparam logic [8:0] LO_TH = 9'(128 - HYST);
    localparam logic [3:0] GLITCH_CNT = 4'(GLITCH);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAD   = 2'd2
    } state_t;

    // Synchroniser stages; bck_d_q is the delayed copy used for edge detection
    logic bck_s1_q, bck_s2_q, bck_d_q;
    logic lrck_s1_q, lrck_s2_q;
    logic dat_s1_q, dat_s2_q;

    state_t                state_q;
    logic [CW-1:0]         bit_cnt_q;
    logic                  chan_q;
    logic [DATA_BITS-2:0]  shreg_q;
    logic                  lrck_prev_q;
    logic                  prev_ok_q;
    logic [15:0]           left_hold_q;
    logic                  left_ok_q;
    logic [15:0]           o_left_q;
    logic [15:0]           o_right_q;
    logic                  valid_q;
    logic                  sync_err_q;
    logic [3:0]            run_q;
    logic                  tapein_q;

    logic                  bck_rise;
    logic                  lr_change;
    logic [DATA_BITS-1:0]  shreg_d;
    logic [15:0]           word_d;
    logic [7:0]            line8;
    logic                  is_hi;
    logic                  is_lo;
    logic                  run_hit;

    // Bring the three asynchronous codec lines into the clk24 domain
    always_ff @(posedge clk24) begin
        if (reset) begin
            bck_s1_q  <= 1'b0;
            bck_s2_q  <= 1'b0;
            bck_d_q   <= 1'b0;
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
            dat_s1_q  <= 1'b0;
            dat_s2_q  <= 1'b0;
        end else begin
            bck_s1_q  <= i_bck;
            bck_s2_q  <= bck_s1_q;
            bck_d_q   <= bck_s2_q;
            lrck_s1_q <= i_lrck;
            lrck_s2_q <= lrck_s1_q;
            dat_s1_q  <= i_adcdat;
            dat_s2_q  <= dat_s1_q;
        end
    end

    // Edge/word decode; a change needs one earlier BCK rise to compare against
    always_comb begin
        bck_rise  = bck_s2_q & ~bck_d_q;
        lr_change = prev_ok_q & (lrck_s2_q != lrck_prev_q);
        shreg_d   = {shreg_q, dat_s2_q};
        word_d    = 16'(shreg_d) << (16 - DATA_BITS);
        line8     = {~o_left_q[15], o_left_q[14:8]};
        is_hi     = {1'b0, line8} > HI_TH;
        is_lo     = {1'b0, line8} < LO_TH;
        run_hit   = tapein_q ? is_lo : is_hi;
    end

    // Framing FSM: hunts for LRCK, shifts a word, pads out the slot, pairs L/R
    always_ff @(posedge clk24) begin
        if (reset) begin
            state_q     <= S_HUNT;
            bit_cnt_q   <= '0;
            chan_q      <= 1'b0;
            shreg_q     <= '0;
            lrck_prev_q <= 1'b0;
            prev_ok_q   <= 1'b0;
            left_hold_q <= 16'h0000;
            left_ok_q   <= 1'b0;
            o_left_q    <= 16'h0000;
            o_right_q   <= 16'h0000;
            valid_q     <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            if (bck_rise) begin
                lrck_prev_q <= lrck_s2_q;
                prev_ok_q   <= 1'b1;
                case (state_q)
                    S_HUNT: begin
                        if (lr_change) begin
                            state_q   <= S_SHIFT;
                            bit_cnt_q <= '0;
                            chan_q    <= lrck_s2_q;
                        end
                    end
                    S_SHIFT: begin
                        if (lr_change) begin
                            // Truncated word: this rise is the new slot's delay bit
                            sync_err_q <= 1'b1;
                            left_ok_q  <= 1'b0;
                            bit_cnt_q  <= '0;
                            chan_q     <= lrck_s2_q;
                        end else begin
                            shreg_q   <= shreg_d[DATA_BITS-2:0];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_CNT) begin
                                state_q <= S_PAD;
                                if (!chan_q) begin
                                    left_hold_q <= word_d;
                                    left_ok_q   <= 1'b1;
                                end else if (left_ok_q) begin
                                    o_left_q  <= left_hold_q;
                                    o_right_q <= word_d;
                                    valid_q   <= 1'b1;
                                    left_ok_q <= 1'b0;
                                end
                            end
                        end
                    end
                    S_PAD: begin
                        if (lr_change) begin
                            state_q   <= S_SHIFT;
                            bit_cnt_q <= '0;
                            chan_q    <= lrck_s2_q;
                        end
                    end
                    default: begin
                        state_q <= S_HUNT;
                    end
                endcase
            end
        end
    end

    // Tape slicer: toggle only after GLITCH consecutive frames past the far threshold
    always_ff @(posedge clk24) begin
        if (reset) begin
            run_q    <= 4'd0;
            tapein_q <= 1'b0;
        end else if (valid_q) begin
            if (run_hit) begin
                if (run_q + 4'd1 >= GLITCH_CNT) begin
                    run_q    <= 4'd0;
                    tapein_q <= ~tapein_q;
                end else begin
                    run_q <= run_q + 4'd1;
                end
            end else begin
                run_q <= 4'd0;
            end
        end
    end

    assign o_left     = o_left_q;
    assign o_right    = o_right_q;
    assign o_valid    = valid_q;
    assign o_sync_err = sync_err_q;
    assign o_tapein   = tapein_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb/tb_i2s_adc_rx.sv - directed table-driven bench for i2s_adc_rx
module tb_i2s_adc_rx;

    logic        clk24 = 1'b0;
    logic        reset;
    logic        i_bck;
    logic        i_lrck;
    logic        i_adcdat;
    logic [15:0] o_left;
    logic [15:0] o_right;
    logic        o_valid;
    logic        o_sync_err;
    logic        o_tapein;

    i2s_adc_rx #(.DATA_BITS(16), .HYST(4), .GLITCH(3)) dut (
        .clk24     (clk24),
        .reset     (reset),
        .i_bck     (i_bck),
        .i_lrck    (i_lrck),
        .i_adcdat  (i_adcdat),
        .o_left    (o_left),
        .o_right   (o_right),
        .o_valid   (o_valid),
        .o_sync_err(o_sync_err),
        .o_tapein  (o_tapein)
    );

    always #5 clk24 = ~clk24;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          reps;
        logic        tap;
    } vec_t;

    vec_t        tbl [9];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          vcnt = 0;
    int          scnt = 0;
    int          valid_cyc = 0;
    int          rise_cyc = 0;
    int          lsb_cyc = 0;
    logic [31:0] vq[$];

    always @(posedge clk24) cyc <= cyc + 1;

    always @(negedge clk24) begin
        if (o_valid) begin
            vcnt++;
            valid_cyc = cyc;
            vq.push_back({o_left, o_right});
        end
        if (o_sync_err) scnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic lr, input logic d);
        i_bck    = 1'b0;
        i_lrck   = lr;
        i_adcdat = d;
        repeat (4) @(posedge clk24);
        #1 i_bck = 1'b1;
        rise_cyc = cyc;
        repeat (4) @(posedge clk24);
        #1;
    endtask

    // k=0 is the I2S delay bit, k=1..16 carry the word MSB first
    task automatic send_half(input logic lr, input logic [15:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            send_bit(lr, (k >= 1 && k <= 16) ? w[16-k] : 1'b0);
            if (k == 16) lsb_cyc = rise_cyc;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_half(1'b0, l, 32);
        send_half(1'b1, r, 32);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        i_bck    = 1'b0;
        i_lrck   = 1'b0;
        i_adcdat = 1'b0;
        repeat (3) @(posedge clk24);
        #1 reset = 1'b0;
    endtask

    initial begin
        int v0, s0;
        // line8 = {~L[15], L[14:8]}: 0x03->131 0x04->132 0x05->133 0xFC->124 0xF8->120
        tbl[0] = '{16'h0300, 16'h8001, 10, 1'b0};
        tbl[1] = '{16'h0400, 16'h1234,  5, 1'b0};
        tbl[2] = '{16'h0500, 16'h7FFF,  2, 1'b0};
        tbl[3] = '{16'h0500, 16'h0000,  1, 1'b1};
        tbl[4] = '{16'hFC00, 16'h5A5A,  5, 1'b1};
        tbl[5] = '{16'hF800, 16'hFFFF,  2, 1'b1};
        tbl[6] = '{16'h0500, 16'hA5A5,  1, 1'b1};
        tbl[7] = '{16'hF800, 16'h0001,  2, 1'b1};
        tbl[8] = '{16'hF800, 16'h8000,  1, 1'b0};

        @(posedge clk24);
        #1 do_reset();

        // Reset state
        @(negedge clk24);
        chk("rst_left", 32'(o_left), 32'h0);
        chk("rst_right", 32'(o_right), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_sync", 32'(o_sync_err), 32'h0);
        chk("rst_tap", 32'(o_tapein), 32'h0);
        @(posedge clk24);
        #1;

        // Frame capture and latency from the right LSB rise
        send_half(1'b1, 16'h0000, 32);
        v0 = vcnt;
        send_frame(16'h1234, 16'hABCD);
        chk("cap_count", 32'(vcnt - v0), 32'd1);
        chk("cap_left", 32'(o_left), 32'h1234);
        chk("cap_right", 32'(o_right), 32'hABCD);
        chk("cap_latency", 32'(valid_cyc - lsb_cyc), 32'd3);

        // LRCK stalls: nothing new, outputs hold
        v0 = vcnt;
        send_half(1'b1, 16'hFFFF, 64);
        chk("stall_count", 32'(vcnt - v0), 32'd0);
        chk("stall_left", 32'(o_left), 32'h1234);

        // Slicer table from a clean reset
        do_reset();
        send_half(1'b1, 16'h0000, 32);
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < tbl[i].reps; j++) begin
                v0 = vcnt;
                send_frame(tbl[i].l, tbl[i].r);
                chk($sformatf("tbl%0d_count", i), 32'(vcnt - v0), 32'd1);
                chk($sformatf("tbl%0d_left", i), 32'(o_left), 32'(tbl[i].l));
                chk($sformatf("tbl%0d_right", i), 32'(o_right), 32'(tbl[i].r));
            end
            chk($sformatf("tbl%0d_tap", i), 32'(o_tapein), 32'(tbl[i].tap));
        end

        // Short left word: one sync error, orphan right word dropped
        v0 = vcnt;
        s0 = scnt;
        send_half(1'b0, 16'hFFFF, 11);
        send_half(1'b1, 16'h1357, 32);
        chk("short_sync", 32'(scnt - s0), 32'd1);
        chk("short_novalid", 32'(vcnt - v0), 32'd0);
        chk("short_hold", 32'(o_left), 32'hF800);
        send_frame(16'h2468, 16'h9BDF);
        chk("short_next_count", 32'(vcnt - v0), 32'd1);
        chk("short_next_left", 32'(o_left), 32'h2468);
        chk("short_next_right", 32'(o_right), 32'h9BDF);
        chk("short_sync_once", 32'(scnt - s0), 32'd1);

        // Reset pulse during a left word
        send_frame(16'h5555, 16'h6666);
        send_half(1'b0, 16'hC3C3, 9);
        reset = 1'b1;
        @(posedge clk24);
        #1 reset = 1'b0;
        @(negedge clk24);
        chk("mid_rst_left", 32'(o_left), 32'h0);
        chk("mid_rst_right", 32'(o_right), 32'h0);
        chk("mid_rst_tap", 32'(o_tapein), 32'h0);
        chk("mid_rst_valid", 32'(o_valid), 32'h0);
        @(posedge clk24);
        #1;
        v0 = vcnt;
        send_half(1'b0, 16'h0000, 23);
        send_half(1'b1, 16'h4321, 32);
        chk("mid_rst_orphan", 32'(vcnt - v0), 32'd0);
        send_frame(16'h7777, 16'h8888);
        chk("mid_rst_count", 32'(vcnt - v0), 32'd1);
        chk("mid_rst_cap", {o_left, o_right}, 32'h77778888);

        // Startup: reset released part-way through a right word
        reset = 1'b1;
        send_half(1'b0, 16'hAAAA, 32);
        send_half(1'b1, 16'h5555, 6);
        vq.delete();
        reset = 1'b0;
        send_half(1'b1, 16'h0000, 26);
        send_frame(16'h0001, 16'h0002);
        send_frame(16'h0003, 16'h0004);
        chk("start_count_ok", 32'(vq.size() == 1 || vq.size() == 2), 32'd1);
        if (vq.size() > 0) begin
            chk("start_first_ok", 32'(vq[0] == 32'h00010002 || vq[0] == 32'h00030004), 32'd1);
            chk("start_last", vq[vq.size()-1], 32'h00030004);
        end else begin
            chk("start_nonempty", 32'(vq.size()), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
